// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one hash-memory port among NUM_REQ engines. Grants are round-robin
//   with whole-job ownership. An owner keeps the port while its req is high.
//   After it drops req, the port sits gated for one dead cycle before the next grant.
//
// Optional feature macro: MEM_PORT_ARB_TIMEOUT_EN
//   Defined:   ownership is limited to TIMEOUT_CYCLES. On expiry the owner is
//              released, flagged in timeout_err, and masked from arbitration
//              until it drops req for at least one cycle.
//   Undefined: ownership is unlimited and timeout_err is tied to 0.
//
// Ports
//   clk, reset        : clock and asynchronous active-high reset
//   req/req_we        : per-requester level request / write enable
//   req_addr/req_wdata: flattened per-requester address / write data
//   gnt, gnt_id, busy : registered one-hot grant, owner index, port-owned flag
//   timeout_err       : sticky per-requester timeout flags
//   mem_clk, mem_we, mem_addr, mem_write_data, mem_read_data : memory port
//   rdata             : mem_read_data broadcast to all requesters
module mem_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [2:0]                gnt_id,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        timeout_err,
  output logic                      mem_clk,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic [DATA_W-1:0]         mem_read_data,
  output logic [DATA_W-1:0]         rdata
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [2:0]           gnt_id_q, gnt_id_d;
  logic [2:0]           last_q, last_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   eligible;
  logic                 timeout_hit;
  logic                 pick_valid;
  logic [2:0]           pick_id;
  logic                 owner_req;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  logic [ADDR_W-1:0]    addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]    wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  // Round-robin search: distance k=1 is the requester after last, k=NUM_REQ
  // is last itself, so the previous owner is always considered last.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pick_valid && (i == idx) && eligible[i]) begin
          pick_valid = 1'b1;
          pick_id    = 3'(i);
        end
      end
    end
  end

  // Owner select; combinational so the arbiter adds no latency to the port.
  always_comb begin
    owner_req = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id_q == 3'(i)) begin
        owner_req = req[i];
        sel_we    = req_we[i];
        sel_addr  = addr_arr[i];
        sel_wdata = wdata_arr[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE, S_RELEASE: begin
        if (pick_valid) begin
          state_d  = S_GRANT;
          gnt_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
          gnt_id_d = pick_id;
          last_d   = pick_id;
          busy_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!owner_req || timeout_hit) begin
          state_d = S_RELEASE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      last_q   <= 3'(NUM_REQ-1);
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
    end
  end

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  logic [15:0]        hold_q, hold_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  assign timeout_hit = (state_q == S_GRANT) && owner_req &&
                       (hold_q == 16'(TIMEOUT_CYCLES-1));
  assign eligible    = req & ~mask_q;
  assign timeout_err = err_q;

  always_comb begin
    hold_d = hold_q;
    // A masked requester is unmasked by any cycle with its req low.
    mask_d = mask_q & req;
    err_d  = err_q;
    if (state_q != S_GRANT && state_d == S_GRANT) begin
      hold_d = '0;
    end else if (state_q == S_GRANT) begin
      hold_d = hold_q + 16'd1;
    end
    if (timeout_hit) begin
      mask_d = mask_d | gnt_q;
      err_d  = err_q | gnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      mask_q <= '0;
      err_q  <= '0;
    end else begin
      hold_q <= hold_d;
      mask_q <= mask_d;
      err_q  <= err_d;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign eligible    = req;
  assign timeout_err = '0;
`endif

  assign gnt            = gnt_q;
  assign gnt_id         = gnt_id_q;
  assign busy           = busy_q;
  assign mem_clk        = clk;
  assign mem_we         = busy_q & sel_we;
  assign mem_addr       = busy_q ? sel_addr : '0;
  assign mem_write_data = busy_q ? sel_wdata : '0;
  assign rdata          = mem_read_data;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single hash-memory port (`mem_addr`, `mem_we`, `mem_write_data`, `mem_read_data`) among up to `NUM_REQ` hashing engines, such as several `bitcoin_hash`/`sha256` instances.
- Grants are round-robin with whole-job ownership: a requester keeps the port for as long as it holds `req`, then hands it on after one dead cycle.
- Sits between the engines and the memory model or SRAM; `mem_clk` is passed through from `clk`.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 32: memory data width.
- `TIMEOUT_CYCLES`, default 4096: maximum ownership length in cycles. Used only when `MEM_PORT_ARB_TIMEOUT_EN` is defined.
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in NUM_REQ: per-requester level request. Held high for the whole job.
- `req_we` in NUM_REQ: per-requester write enable.
- `req_addr` in NUM_REQ*ADDR_W: flattened addresses. Requester i uses slice [i*ADDR_W +: ADDR_W].
- `req_wdata` in NUM_REQ*DATA_W: flattened write data, sliced the same way.
- `gnt` out NUM_REQ: one-hot grant, registered.
- `gnt_id` out 3: index of the current owner. Valid while `busy`=1.
- `busy` out 1: high when some requester owns the port.
- `timeout_err` out NUM_REQ: sticky per-requester timeout flags.
- `mem_clk` out 1: equal to `clk`.
- `mem_we` out 1: owner's `req_we`, gated.
- `mem_addr` out ADDR_W: owner's address, gated.
- `mem_write_data` out DATA_W: owner's write data, gated.
- `mem_read_data` in DATA_W: memory read data.
- `rdata` out DATA_W: `mem_read_data` broadcast unmodified to all requesters.

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- Reset values: state=IDLE, `gnt`=0, `gnt_id`=0, `busy`=0, `timeout_err`=0, round-robin pointer `last`=NUM_REQ-1.
- IDLE:
  - If any `req` is high, choose the first requester with `req` high, searching from (`last`+1) mod NUM_REQ upward with wrap.
  - Set `gnt`, `gnt_id`, `last` and `busy`=1, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - While `req[gnt_id]`=1, stay; the output mux selects the owner.
  - When `req[gnt_id]`=0, clear `gnt` and `busy` and go to RELEASE.
- RELEASE:
  - Exactly one cycle with the port gated.
  - Then apply the same arbitration as IDLE: go to GRANT if any `req` is high, else to IDLE.
  - The releasing requester is eligible again but is searched last.
- Output mux:
  - When `busy`=0: `mem_we`=0, `mem_addr`=0, `mem_write_data`=0.
  - When `busy`=1: the outputs are the combinational select of the owner's slices.
- A non-owner's `req_we`, `req_addr` and `req_wdata` are ignored.
- Simultaneous requests are resolved purely by the round-robin order.
- A requester that raises `req` while another requester owns the port waits; it is never preempted in and never dropped.
- `req` pulses shorter than the time to grant are not remembered: `req` is a level, not an event.
- `gnt_id` holds its last value while not busy.

## Timing
- Request to grant: `req` high and sampled at edge N in IDLE, so `gnt` is high from edge N onward, i.e. visible in the cycle after `req` is first seen.
- The owner must not drive accesses until it sees its `gnt`=1.
- Release to next grant:
  - The owner drops `req` before edge N and is sampled there; `gnt` is 0 after edge N (RELEASE).
  - The next `gnt` is high after edge N+1.
  - This gives one dead cycle with `mem_we`=0.
- Read latency is that of the memory only. The arbiter adds no register stage on the address or data path.
- `reset` asserted mid-grant:
  - `gnt`, `busy` and `mem_we` drop immediately, asynchronously.
  - The pointer returns to NUM_REQ-1, so requester 0 wins first after reset.

## Configuration
- `MEM_PORT_ARB_TIMEOUT_EN` defined:
  - A 16-bit hold counter clears on every grant and increments each GRANT cycle.
  - When it reaches `TIMEOUT_CYCLES`-1 with `req` still high, force RELEASE and set `timeout_err[gnt_id]`.
  - That requester is masked from arbitration until it deasserts `req` for at least one cycle.
  - `timeout_err` clears only on `reset`.
- Macro undefined:
  - No counter; ownership is unlimited.
  - `timeout_err` is tied to 0.

## Test plan
- Reset, then `req`=4'b0001: `gnt`=0001 one edge later; `mem_addr` follows `req_addr[15:0]`=16'h0010; `mem_we`=0 before the grant.
- `req`=4'b1111 held, with each owner dropping `req` after 20 cycles of ownership: grant order is 0,1,2,3,0; one `busy`=0 cycle between owners.
- Owner 2 active and requester 1 rises: requester 1 is granted only after 2 releases, with exactly 1 dead cycle; a write from non-owner 1 never reaches `mem_we`.
- Assert `reset` mid-write (owner 3, `req_we`=1): `mem_we`=0 the same cycle; after release of reset with `req`=4'b1001, requester 0 is granted first.
- With `MEM_PORT_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, requester 1 holds `req`: `gnt` drops after 8 cycles and `timeout_err`=0010. Requester 1 is not regranted until `req[1]` drops for one cycle, while requester 2 is granted in the meantime.
- With the macro undefined, requester 0 holds the port for 10000 cycles: `gnt` stays high and `timeout_err` stays 0.
